// File: rtl/cpu8051_pkg.sv
// rtl/cpu8051_pkg.sv - shared constants, state encoding and helpers for 8051 register blocks
package cpu8051_pkg;

    localparam logic LOAD_IDLE = 1'b0;
    localparam logic LOAD_BUSY = 1'b1;
    localparam int   BYTE_W    = 8;

    typedef enum logic {
        ST_IDLE = LOAD_IDLE,
        ST_LOAD = LOAD_BUSY
    } load_state_e;

    // A one-lane register still needs a 1-bit select/counter, so never return 0.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - shadow word, byte counter and stream-position to lane mapping for serial loads
module byte_assembler
    import cpu8051_pkg::*;
#(
    parameter int BYTES     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    accept,
    input  logic [BYTE_W-1:0]       din,
    output logic [BYTES*BYTE_W-1:0] word_out,
    output logic                    last_byte
);

    localparam int W     = BYTES * BYTE_W;
    localparam int CNT_W = clog2_min1(BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < BYTES; i++) begin
            // Lane i takes the byte whose stream position maps onto it.
            if (accept && (cnt_q == CNT_W'(MSB_FIRST ? (BYTES - 1 - i) : i))) begin
                shadow_d[i*BYTE_W +: BYTE_W] = din;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
        end
    end

    assign last_byte = accept && (cnt_q == CNT_LAST);
    // Merged view so the final byte commits in the same edge it is accepted.
    assign word_out  = shadow_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/byte_load_register.sv
// rtl/byte_load_register.sv - multi-byte register with lane, word and serial loads plus inc/dec stepping
module byte_load_register
    import cpu8051_pkg::*;
#(
    parameter int                  BYTES     = 2,
    parameter bit                  MSB_FIRST = 1'b1,
    parameter logic [8*BYTES-1:0]  RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           word_we,
    input  logic [8*BYTES-1:0]             word_in,
    input  logic                           byte_we,
    input  logic [clog2_min1(BYTES)-1:0]   byte_sel,
    input  logic [BYTE_W-1:0]              din,
    input  logic                           inc,
    input  logic                           dec,
    input  logic                           ser_start,
    input  logic                           ser_valid,
    input  logic                           ser_abort,
    output logic                           ser_ready,
    output logic                           ser_busy,
    output logic                           ser_done,
    output logic                           wrap,
    output logic [8*BYTES-1:0]             out
);

    localparam int W     = 8 * BYTES;
    localparam int SEL_W = clog2_min1(BYTES);
    localparam logic [W-1:0] ONE = W'(1);

    load_state_e state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic         wrap_q, wrap_d;
    logic         done_q, done_d;

    logic         in_load;
    logic         asm_clear;
    logic         asm_accept;
    logic         last_byte;
    logic [W-1:0] asm_word;

    assign in_load    = (state_q == ST_LOAD);
    assign asm_clear  = in_load ? ser_abort : ser_start;
    // Abort wins over a byte presented in the same cycle.
    assign asm_accept = in_load && ser_valid && !ser_abort;

    byte_assembler #(
        .BYTES     (BYTES),
        .MSB_FIRST (MSB_FIRST)
    ) u_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .accept    (asm_accept),
        .din       (din),
        .word_out  (asm_word),
        .last_byte (last_byte)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ser_start) begin
                    state_d = ST_LOAD;
                end else if (word_we) begin
                    out_d = word_in;
                end else if (byte_we) begin
                    // Out-of-range selects match no lane and leave out untouched.
                    for (int i = 0; i < BYTES; i++) begin
                        if (byte_sel == SEL_W'(i)) begin
                            out_d[i*BYTE_W +: BYTE_W] = din;
                        end
                    end
                end else if (inc && !dec) begin
                    out_d  = out_q + ONE;
                    wrap_d = &out_q;
                end else if (dec && !inc) begin
                    out_d  = out_q - ONE;
                    wrap_d = ~|out_q;
                end
            end
            ST_LOAD: begin
                if (ser_abort) begin
                    state_d = ST_IDLE;
                end else if (last_byte) begin
                    out_d   = asm_word;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= RESET_VAL;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign ser_ready = in_load;
    assign ser_busy  = in_load;
    assign ser_done  = done_q;
    assign wrap      = wrap_q;
    assign out       = out_q;

endmodule
